// File: rtl/block_mem_responder_pkg.sv
// Shared definitions for the block memory responder: default geometry,
// the offset field width and the FSM state encodings.
package block_mem_responder_pkg;

  localparam int WORD_SIZE_DEF  = 32;
  localparam int BLOCK_SIZE_DEF = 16;
  localparam int OFFSET_BITS    = 4;
  localparam int MEM_BLOCKS_DEF = 1024;
  localparam int LATENCY_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/block_mem_responder_block_ram.sv
// Single-port synchronous block storage. One read or write per enabled
// cycle. The output register captures the read data on a read and the
// write data on a write (write-first), so it can serve directly as the
// response block. The output register resets to zero; the array does not.
module block_ram #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array write port
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= din;
    end
  end

  // Output register: write-first, holds its value while not enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (en) begin
      dout <= we ? din : mem[addr];
    end
  end

endmodule

// File: rtl/block_mem_responder.sv
// Memory-side responder for data cache block refill and write-back.
// Accepts one full-block read or write, waits LATENCY cycles, performs the
// access, then presents the block (or write echo) until it is taken.
// Optional macro BLOCK_MEM_STATS_EN adds stat_reads / stat_writes counters.
module block_mem_responder
  import block_mem_responder_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int MEM_BLOCKS = MEM_BLOCKS_DEF,
  parameter int LATENCY    = LATENCY_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [WORD_SIZE-1:0]            req_addr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] req_block,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic                            resp_write,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] resp_block
`ifdef BLOCK_MEM_STATS_EN
  ,
  output logic [31:0]                     stat_reads,
  output logic [31:0]                     stat_writes
`endif
);

  localparam int BLK_W = WORD_SIZE * BLOCK_SIZE;
  localparam int IDX_W = $clog2(MEM_BLOCKS);

  state_t             state, state_nxt;
  logic [7:0]         cnt_p0;
  logic               lat_write_p0;
  logic [IDX_W-1:0]   lat_idx_p0;
  logic [BLK_W-1:0]   lat_data_p0;
  logic               accept;
  logic               commit;
  logic               unused_addr;

  // Offset and upper address bits do not select storage; upper bits alias.
  assign unused_addr = ^{req_addr[WORD_SIZE-1:OFFSET_BITS+IDX_W],
                         req_addr[OFFSET_BITS-1:0]};

  assign accept     = req_valid && req_ready;
  assign commit     = (state == ST_WAIT) && (cnt_p0 == 8'd0);
  assign resp_valid = (state == ST_RESP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and request-side handshake
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_p0 == 8'd0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latency counter and response write flag (control, reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0       <= 8'd0;
      lat_write_p0 <= 1'b0;
      resp_write   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_p0       <= 8'(LATENCY - 1);
        lat_write_p0 <= req_write;
      end else if (state == ST_WAIT && cnt_p0 != 8'd0) begin
        cnt_p0 <= cnt_p0 - 8'd1;
      end
      if (commit) begin
        resp_write <= lat_write_p0;
      end
    end
  end

  // Request index and data latches (data path, not reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_idx_p0  <= req_addr[OFFSET_BITS +: IDX_W];
      lat_data_p0 <= req_block;
    end
  end

  // ---- commit stage: storage access, output register becomes resp_block ----
  block_ram #(
    .WIDTH (BLK_W),
    .DEPTH (MEM_BLOCKS),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit),
    .we    (lat_write_p0),
    .addr  (lat_idx_p0),
    .din   (lat_data_p0),
    .dout  (resp_block)
  );

`ifdef BLOCK_MEM_STATS_EN
  // Committed access counters, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads  <= 32'd0;
      stat_writes <= 32'd0;
    end else if (commit) begin
      if (lat_write_p0) stat_writes <= stat_writes + 32'd1;
      else              stat_reads  <= stat_reads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: instance 0 with LATENCY=4,
// instance 1 with LATENCY=1. Optional stats checked when
// BLOCK_MEM_STATS_EN is defined.
module tb_block_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid  [2];
  logic         req_write  [2];
  logic [31:0]  req_addr   [2];
  logic [511:0] req_block  [2];
  logic         resp_ready [2];
  logic         req_ready  [2];
  logic         resp_valid [2];
  logic         resp_write [2];
  logic [511:0] resp_block [2];
`ifdef BLOCK_MEM_STATS_EN
  logic [31:0]  stat_reads  [2];
  logic [31:0]  stat_writes [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  block_mem_responder #(.LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_block(req_block[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_write(resp_write[0]), .resp_block(resp_block[0])
`ifdef BLOCK_MEM_STATS_EN
    , .stat_reads(stat_reads[0]), .stat_writes(stat_writes[0])
`endif
  );

  block_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_block(req_block[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_write(resp_write[1]), .resp_block(resp_block[1])
`ifdef BLOCK_MEM_STATS_EN
    , .stat_reads(stat_reads[1]), .stat_writes(stat_writes[1])
`endif
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Block whose word at offset k is base+k, offset 0 in the MSBs
  function automatic logic [511:0] mk(input logic [31:0] base);
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[(15-k)*32 +: 32] = base + 32'(k);
    return b;
  endfunction

  // Issue one request, then measure cycles until resp_valid and check the response
  task automatic txn(input int d, input logic w, input logic [31:0] addr,
                     input logic [511:0] blk, input logic [511:0] exp, input string tag);
    int cyc;
    int lat;
    lat = (d == 0) ? 4 : 1;
    @(negedge clk);
    chk({tag, " ready"}, 512'(req_ready[d]), 512'd1);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = addr;
    req_block[d] = blk;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = ~addr;
    req_block[d] = ~blk;
    req_write[d] = ~w;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (resp_valid[d]) break;
    end
    chk({tag, " latency"}, 512'(cyc), 512'(lat));
    chk({tag, " resp_write"}, 512'(resp_write[d]), 512'(w));
    chk({tag, " resp_block"}, resp_block[d], exp);
  endtask

  // Take the pending response and confirm return to IDLE
  task automatic take(input int d, input string tag);
    @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    chk({tag, " valid drop"}, 512'(resp_valid[d]), 512'd0);
    chk({tag, " idle ready"}, 512'(req_ready[d]), 512'd1);
  endtask

  initial begin
    logic [511:0] blk_a, blk_b, blk_c;
    blk_a = mk(32'hA000_0000);
    blk_b = mk(32'hB000_0000);
    blk_c = mk(32'hC000_0000);
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_block[d] = '0;   resp_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 512'(req_ready[0]), 512'd1);
    chk("reset resp_valid", 512'(resp_valid[0]), 512'd0);
    chk("reset resp_write", 512'(resp_write[0]), 512'd0);
    chk("reset resp_block", resp_block[0], 512'd0);
    rst_n = 1'b1;

    // Write then read back the same block via a different offset
    txn(0, 1'b1, 32'h0000_0150, blk_a, blk_a, "wrA");
    take(0, "wrA");
    txn(0, 1'b0, 32'h0000_015F, '1, blk_a, "rdA");
    chk("rdA msw", 512'(resp_block[0][511:480]), 512'(32'hA000_0000));
    chk("rdA lsw", 512'(resp_block[0][31:0]), 512'(32'hA000_000F));
    take(0, "rdA");

    // Aliasing: 0x0004_0010 maps to index 1
    txn(0, 1'b1, 32'h0000_0010, blk_b, blk_b, "wrB");
    take(0, "wrB");
    txn(0, 1'b0, 32'h0004_0010, '0, blk_b, "rdAlias");
    take(0, "rdAlias");

    // Stall in RESP with request pulses that must be ignored
    txn(0, 1'b0, 32'h0000_0150, '0, blk_a, "rdHold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold valid", 512'(resp_valid[0]), 512'd1);
      chk("hold block", resp_block[0], blk_a);
      chk("hold ready", 512'(req_ready[0]), 512'd0);
      req_valid[0] = i[0];
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h0000_0150;
      req_block[0] = blk_c;
    end
    req_valid[0] = 1'b0;
    take(0, "rdHold");
    txn(0, 1'b0, 32'h0000_0150, '0, blk_a, "noCorrupt");
    take(0, "noCorrupt");

    // Asynchronous reset in RESP discards the response immediately
    txn(0, 1'b0, 32'h0000_0010, '0, blk_b, "rdB2");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstResp valid", 512'(resp_valid[0]), 512'd0);
    chk("rstResp block", resp_block[0], 512'd0);
    chk("rstResp ready", 512'(req_ready[0]), 512'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT at counter=1 drops the write
    txn(0, 1'b1, 32'h0000_0050, '0, '0, "wrZero");
    take(0, "wrZero");
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 32'h0000_0050; req_block[0] = blk_c;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstWait valid", 512'(resp_valid[0]), 512'd0);
    chk("rstWait ready", 512'(req_ready[0]), 512'd1);
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h0000_0050, '0, '0, "rdDropped");
    take(0, "rdDropped");

    // LATENCY=1 instance: 3 writes, 5 reads
    txn(1, 1'b1, 32'h0000_0020, mk(32'hD000_0000), mk(32'hD000_0000), "l1wrD");
    take(1, "l1wrD");
    txn(1, 1'b1, 32'h0000_0030, mk(32'hE000_0000), mk(32'hE000_0000), "l1wrE");
    take(1, "l1wrE");
    txn(1, 1'b1, 32'h0000_0040, mk(32'hF000_0000), mk(32'hF000_0000), "l1wrF");
    take(1, "l1wrF");
    txn(1, 1'b0, 32'h0000_0021, '0, mk(32'hD000_0000), "l1rdD");
    take(1, "l1rdD");
    txn(1, 1'b0, 32'h0000_0032, '0, mk(32'hE000_0000), "l1rdE");
    take(1, "l1rdE");
    txn(1, 1'b0, 32'h0000_0043, '0, mk(32'hF000_0000), "l1rdF");
    take(1, "l1rdF");
    txn(1, 1'b0, 32'h0010_0020, '0, mk(32'hD000_0000), "l1rdAlias");
    take(1, "l1rdAlias");
    txn(1, 1'b0, 32'h0000_003F, '0, mk(32'hE000_0000), "l1rdE2");
    take(1, "l1rdE2");
`ifdef BLOCK_MEM_STATS_EN
    @(negedge clk);
    chk("stat_writes", 512'(stat_writes[1]), 512'd3);
    chk("stat_reads", 512'(stat_reads[1]), 512'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
